// File: rtl/nexys_starship_pkg.sv
// Shared encodings for the starship game: FSM states, position indices and the
// 4-bit position vector used by the spawn scheduler and the position SMs.
package nexys_starship_pkg;

   localparam int POS_W = 4;
   localparam int TOP   = 0;
   localparam int BTM   = 1;
   localparam int LEFT  = 2;
   localparam int RIGHT = 3;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_COOLDOWN = 3'd1;
   localparam logic [2:0] ST_ARB      = 3'd2;
   localparam logic [2:0] ST_SPAWN    = 3'd3;
   localparam logic [2:0] ST_HALT     = 3'd4;

   typedef logic [POS_W-1:0] pos_vec_t;

   function automatic logic [2:0] popcnt4(input pos_vec_t v);
      return 3'(v[TOP]) + 3'(v[BTM]) + 3'(v[LEFT]) + 3'(v[RIGHT]);
   endfunction

   // Index of a one-hot position vector; only meaningful when v is one-hot.
   function automatic logic [1:0] oh2idx(input pos_vec_t v);
      logic [1:0] idx;
      idx = 2'(TOP);
      if (v[BTM])   idx = 2'(BTM);
      if (v[LEFT])  idx = 2'(LEFT);
      if (v[RIGHT]) idx = 2'(RIGHT);
      return idx;
   endfunction

endpackage

// File: rtl/nexys_starship_spawn_sched_if.sv
// Position bus between the spawn scheduler (master) and the monster position SMs.
interface nexys_starship_spawn_sched_if;
   import nexys_starship_pkg::*;

   pos_vec_t   rand_req;
   pos_vec_t   monster_clear;
   pos_vec_t   spawn;
   pos_vec_t   active;
   logic [2:0] active_cnt;
   logic       sched_full;

   modport master (
      input  rand_req, monster_clear,
      output spawn, active, active_cnt, sched_full
   );
   modport slave (
      output rand_req, monster_clear,
      input  spawn, active, active_cnt, sched_full
   );
endinterface

// File: rtl/nexys_starship_rr_arb4.sv
// Four-way round-robin arbiter: first requester at or after ptr wins (one-hot).
module nexys_starship_rr_arb4
   import nexys_starship_pkg::*;
(
   input  pos_vec_t   req,
   input  logic [1:0] ptr,
   output pos_vec_t   gnt
);
   logic [1:0] idx;
   logic       found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < POS_W; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/nexys_starship_spawn_sched.sv
// Monster spawn scheduler: tick-driven cooldown, round-robin grant over free positions.
// Define STARSHIP_SPAWN_ESCALATE_EN to shorten the cooldown every 8 spawns.
module nexys_starship_spawn_sched
   import nexys_starship_pkg::*;
#(
   parameter int SPAWN_INTERVAL = 16,
   parameter int MAX_ACTIVE     = 2
) (
   input  logic Clk,
   input  logic Reset,
   input  logic tick,
   input  logic play_flag,
   input  logic game_over,
   nexys_starship_spawn_sched_if.master pos
);
   logic [2:0] state;
   logic [7:0] cooldown;
   logic [7:0] reload;
   logic [1:0] rr_ptr;
   pos_vec_t   spawn_r, active_r, eligible, grant;
   logic [2:0] active_cnt;
   logic       full;

`ifdef STARSHIP_SPAWN_ESCALATE_EN
   logic [1:0] level;
   logic [2:0] spawn_cnt;
   assign reload = 8'(SPAWN_INTERVAL) >> level;
`else
   assign reload = 8'(SPAWN_INTERVAL);
`endif

   assign active_cnt     = popcnt4(active_r);
   assign full           = (active_cnt == 3'(MAX_ACTIVE));
   assign eligible       = pos.rand_req & ~active_r;
   assign pos.spawn      = spawn_r;
   assign pos.active     = active_r;
   assign pos.active_cnt = active_cnt;
   assign pos.sched_full = full;

   nexys_starship_rr_arb4 u_arb (.req(eligible), .ptr(rr_ptr), .gnt(grant));

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= ST_IDLE;
         spawn_r  <= '0;
         active_r <= '0;
         rr_ptr   <= 2'(TOP);
         cooldown <= '0;
`ifdef STARSHIP_SPAWN_ESCALATE_EN
         level     <= '0;
         spawn_cnt <= '0;
`endif
      // From IDLE with play low there is nothing to halt; HALT would exit at once.
      end else if (game_over && state != ST_HALT && (state != ST_IDLE || play_flag)) begin
         state    <= ST_HALT;
         spawn_r  <= '0;
         active_r <= '0;
      end else if (!play_flag && state != ST_HALT) begin
         state    <= ST_IDLE;
         spawn_r  <= '0;
         active_r <= '0;
      end else begin
         spawn_r  <= '0;
         active_r <= active_r & ~pos.monster_clear;
         case (state)
            ST_IDLE: begin
               state    <= ST_COOLDOWN;
               cooldown <= 8'(SPAWN_INTERVAL);
`ifdef STARSHIP_SPAWN_ESCALATE_EN
               level     <= '0;
               spawn_cnt <= '0;
`endif
            end
            ST_COOLDOWN: begin
               if (cooldown == '0) begin
                  state <= ST_ARB;
               end else if (tick) begin
                  cooldown <= cooldown - 8'd1;
                  if (cooldown == 8'd1) state <= ST_ARB;
               end
            end
            // Decision uses registered active/count; a clear this cycle helps next cycle.
            ST_ARB: begin
               if (eligible != '0 && !full) begin
                  spawn_r  <= grant;
                  active_r <= (active_r & ~pos.monster_clear) | grant;
                  rr_ptr   <= oh2idx(grant) + 2'd1;
                  state    <= ST_SPAWN;
`ifdef STARSHIP_SPAWN_ESCALATE_EN
                  spawn_cnt <= spawn_cnt + 3'd1;
                  if (spawn_cnt == 3'd7 && level != 2'd3) level <= level + 2'd1;
`endif
               end
            end
            ST_SPAWN: begin
               state    <= ST_COOLDOWN;
               cooldown <= reload;
            end
            ST_HALT: begin
               if (!play_flag) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/nexys_starship_spawn_sched.md
NEXYS_STARSHIP_SPAWN_SCHED -- requirements
Module: nexys_starship_spawn_sched

Interface
REQ-001 SHALL have parameter SPAWN_INTERVAL, default 16, meaning cooldown length in tick pulses between spawn attempts (range 2..255).
REQ-002 SHALL have parameter MAX_ACTIVE, default 2, meaning the maximum number of simultaneously occupied monster positions (range 1..4).
REQ-003 SHALL have port Clk, input, 1, system clock (100 MHz).
REQ-004 SHALL have port Reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port tick, input, 1, single-cycle enable from the clock divider; cooldown advances only on tick=1.
REQ-006 SHALL have port play_flag, input, 1, high while the game SM is in Play.
REQ-007 SHALL have port game_over, input, 1, high when the game has ended.
REQ-008 SHALL have port rand_req, input, 4, PRNG request bits ordered {right, left, btm, top}.
REQ-009 SHALL have port monster_clear, input, 4, one-cycle pulses from the position SMs when a monster is defeated; same bit order.
REQ-010 SHALL have port spawn, output, 4, one-hot single-cycle spawn pulse to the position SMs.
REQ-011 SHALL have port active, output, 4, the currently occupied positions.
REQ-012 SHALL have port active_cnt, output, 3, the population count of active.
REQ-013 SHALL have port sched_full, output, 1, high when active_cnt equals MAX_ACTIVE.

Function
REQ-014 SHALL implement the states IDLE, COOLDOWN, ARB, SPAWN and HALT.
REQ-015 SHALL move IDLE->COOLDOWN when play_flag=1 and game_over=0, loading the cooldown counter with the current reload value.
REQ-016 In COOLDOWN, SHALL decrement the counter on each tick and enter ARB in the cycle after the counter reaches 0.
REQ-017 In ARB, SHALL compute eligible = rand_req & ~active, then: if eligible==0 or active_cnt==MAX_ACTIVE, stay in ARB; otherwise grant round-robin from the position after the last grant and enter SPAWN.
REQ-018 In SPAWN, SHALL assert spawn for exactly one cycle with the granted bit, set that bit in active in the same cycle, advance the round-robin pointer to grant+1 mod 4, and return to COOLDOWN with the counter reloaded.
REQ-019 monster_clear on an active bit SHALL clear that bit on the next edge; monster_clear on an inactive bit SHALL be ignored.
REQ-020 A clear and a spawn on different bits in the same cycle SHALL both take effect; active_cnt SHALL reflect the net result one cycle later.
REQ-021 ARB SHALL use the registered active and active_cnt; a clear in the ARB cycle SHALL not enable a grant until the following cycle.
REQ-022 game_over=1 in any state SHALL force HALT on the next edge: spawn=0, active cleared to 0, cooldown frozen.
REQ-023 HALT SHALL persist until play_flag=0; the block SHALL then enter IDLE.
REQ-024 play_flag falling outside HALT SHALL force IDLE and clear active.
REQ-025 spawn SHALL never be asserted outside the SPAWN state and SHALL never have more than one bit set.
REQ-026 All outputs SHALL be registered, except active_cnt and sched_full, which are decoded combinationally from active.

Reset
REQ-027 Reset=0 at a Clk edge SHALL force state IDLE, spawn=0, active=0, round-robin pointer=0 (top), cooldown=0 and escalation level=0.
REQ-028 Reset asserted mid-operation, including during SPAWN, SHALL discard any pending grant without emitting a spawn pulse.

Configuration
REQ-029 With STARSHIP_SPAWN_ESCALATE_EN defined, the reload value SHALL be SPAWN_INTERVAL >> level, where a 2-bit level increments after every 8th spawn and saturates at 3; level SHALL reset on the IDLE->COOLDOWN transition.
REQ-030 Without STARSHIP_SPAWN_ESCALATE_EN, the reload value SHALL be SPAWN_INTERVAL for all spawns, with no level register present.

Structure
REQ-031 The shared package nexys_starship_pkg SHALL hold the state encodings, the position index constants (TOP=0, BTM=1, LEFT=2, RIGHT=3) and the width of the 4-bit position vector.
REQ-032 The round-robin grant logic SHALL be one sub-module, nexys_starship_rr_arb4 (inputs: request, pointer; output: one-hot grant).

Verification
REQ-033 SHALL test basic spawn: SPAWN_INTERVAL=4, rand_req=4'b0001, play_flag raised -> spawn=4'b0001 for 1 cycle after 4 ticks + 1 cycle; active=4'b0001.
REQ-034 SHALL test round-robin: rand_req=4'b1111 held, monster_clear pulsed after each spawn -> spawn sequence 0001, 0010, 0100, 1000, 0001.
REQ-035 SHALL test full: MAX_ACTIVE=2, two spawns, rand_req=4'b1111 -> sched_full=1 and no spawn; pulse monster_clear=4'b0001 -> next spawn occurs no earlier than 2 cycles later.
REQ-036 SHALL test game over: game_over=1 during COOLDOWN with active=4'b0011 -> HALT, active=0, spawn stays 0 until play_flag=0 and IDLE is reached.
REQ-037 SHALL test reset mid-SPAWN: Reset=0 in the SPAWN cycle -> spawn=0 and active=0 at the next edge.
REQ-038 SHALL test escalation with STARSHIP_SPAWN_ESCALATE_EN defined, SPAWN_INTERVAL=16: after 8 spawns the cooldown is 8 ticks, and after 24 spawns it stays 2 ticks.
